// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter. It holds ps2c low for request-to-send, then shifts 8 data bits and an odd
// parity bit on device clock falls, checks the device ack, and aborts if the device stops clocking.
module ps2_tx #(
   parameter int RTS_CYCLES     = 5000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_ps2,
   input  logic [7:0] din,
   inout  wire        ps2d,
   inout  wire        ps2c,
   output logic       tx_idle,
   output logic       tx_done_tick,
   output logic       ack_err,
   output logic       tout_err
);
   localparam int RW = $clog2(RTS_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, RTS, START, DATA, ACK, WAIT_IDLE} state_t;

   state_t                state, state_n;
   logic                  c_en, d_en, c_en_n, d_en_n;
   logic [FILTER_LEN-1:0] filt, filt_n;
   logic                  f_val, f_val_n, fall_edge;
   logic [8:0]            frame;
   logic [3:0]            bit_cnt, bit_cnt_n;
   logic [RW-1:0]         rts_cnt;
   logic [TW-1:0]         tout_cnt;
   logic                  accept, ack_smp, tout_abort, done_n, counting;

   assign filt_n    = {ps2c, filt[FILTER_LEN-1:1]};
   assign f_val_n   = (&filt_n) ? 1'b1 : ((|filt_n) ? f_val : 1'b0);
   assign fall_edge = f_val & ~f_val_n;
   assign counting  = (state == START) || (state == DATA) || (state == ACK) || (state == WAIT_IDLE);

   always_comb begin
      state_n    = state;
      c_en_n     = c_en;
      d_en_n     = d_en;
      bit_cnt_n  = bit_cnt;
      accept     = 1'b0;
      ack_smp    = 1'b0;
      tout_abort = 1'b0;
      done_n     = 1'b0;
      case (state)
         IDLE: begin
            c_en_n = 1'b0;
            d_en_n = 1'b0;
            if (wr_ps2) begin
               accept  = 1'b1;
               c_en_n  = 1'b1;
               state_n = RTS;
            end
         end
         RTS: begin
            // Start bit goes out one cycle before the clock is released.
            c_en_n = 1'b1;
            d_en_n = (rts_cnt <= RW'(1));
            if (rts_cnt == '0) begin
               c_en_n  = 1'b0;
               d_en_n  = 1'b1;
               state_n = START;
            end
         end
         START: begin
            c_en_n = 1'b0;
            d_en_n = 1'b1;
            if (fall_edge) begin
               d_en_n    = ~frame[0];
               bit_cnt_n = 4'd1;
               state_n   = DATA;
            end
         end
         DATA: begin
            if (fall_edge) begin
               if (bit_cnt == 4'd9) begin
                  d_en_n  = 1'b0;
                  state_n = ACK;
               end else begin
                  d_en_n    = ~frame[bit_cnt];
                  bit_cnt_n = bit_cnt + 4'd1;
               end
            end
         end
         ACK: begin
            d_en_n = 1'b0;
            if (fall_edge) begin
               ack_smp = 1'b1;
               state_n = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (f_val && ps2d) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      if (counting && !fall_edge && !done_n && tout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
         c_en_n     = 1'b0;
         d_en_n     = 1'b0;
         tout_abort = 1'b1;
         done_n     = 1'b1;
         state_n    = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         c_en         <= 1'b0;
         d_en         <= 1'b0;
         filt         <= '1;
         f_val        <= 1'b1;
         frame        <= '0;
         bit_cnt      <= '0;
         rts_cnt      <= '0;
         tout_cnt     <= '0;
         tx_done_tick <= 1'b0;
         ack_err      <= 1'b0;
         tout_err     <= 1'b0;
      end else begin
         state        <= state_n;
         c_en         <= c_en_n;
         d_en         <= d_en_n;
         filt         <= filt_n;
         f_val        <= f_val_n;
         bit_cnt      <= bit_cnt_n;
         tx_done_tick <= done_n;
         if (accept) begin
            frame    <= {~^din, din};
            ack_err  <= 1'b0;
            tout_err <= 1'b0;
            rts_cnt  <= RW'(RTS_CYCLES - 1);
         end else if (state == RTS && rts_cnt != '0) begin
            rts_cnt <= rts_cnt - RW'(1);
         end
         if (ack_smp)
            ack_err <= ps2d;
         if (tout_abort)
            tout_err <= 1'b1;
         if (!counting || fall_edge || state_n != state)
            tout_cnt <= '0;
         else
            tout_cnt <= tout_cnt + TW'(1);
      end
   end

   assign ps2c    = c_en ? 1'b0 : 1'bz;
   assign ps2d    = d_en ? 1'b0 : 1'bz;
   assign tx_idle = (state == IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a device model clocks the bus and captures the 11-bit frame, checked against hand-computed vectors.
module tb_ps2_tx;
   logic       clk = 1'b0;
   logic       reset;
   logic       wr_ps2;
   logic [7:0] din;
   logic       tx_idle, tx_done_tick, ack_err, tout_err;
   logic       dev_c_low, dev_d_low;
   wire        ps2c, ps2d;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;

   assign ps2c = dev_c_low ? 1'b0 : 1'bz;
   assign ps2d = dev_d_low ? 1'b0 : 1'bz;
   pullup pu_c (ps2c);
   pullup pu_d (ps2d);

   ps2_tx #(.RTS_CYCLES(20), .TIMEOUT_CYCLES(200), .FILTER_LEN(4)) dut (
      .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din), .ps2d(ps2d), .ps2c(ps2c),
      .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .ack_err(ack_err), .tout_err(tout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (tx_done_tick) done_cnt = done_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      din    = b;
      wr_ps2 = 1'b1;
      @(negedge clk);
      wr_ps2 = 1'b0;
      chk("tx_idle_drop", {31'd0, tx_idle}, 32'd0);
   endtask

   // Device side: measures RTS, captures start/data/parity/stop on ps2c rising edges, optionally acks.
   task automatic dev_run(input bit drive_ack, input int max_falls, input int glitch_at,
                          output logic [10:0] cap, output int rts_len, output logic d_before);
      int n;
      cap = '0;
      d_before = 1'b1;
      n = 0;
      while (ps2c !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      n = 0;
      while (ps2c !== 1'b1 && n < 100) begin
         d_before = ps2d;
         @(negedge clk);
         n++;
      end
      rts_len = n;
      cap[0] = ps2d;
      for (int f = 1; f <= 11; f++) begin
         if (f > max_falls) break;
         if (f == glitch_at) begin
            repeat (10) @(negedge clk);
            dev_c_low = 1'b1;
            @(negedge clk);
            dev_c_low = 1'b0;
            repeat (9) @(negedge clk);
         end else begin
            repeat (20) @(negedge clk);
         end
         dev_c_low = 1'b1;
         repeat (20) @(negedge clk);
         dev_c_low = 1'b0;
         if (f <= 10) cap[f] = ps2d;
         if (f == 10) dev_d_low = drive_ack;
         if (f == 11) dev_d_low = 1'b0;
      end
   endtask

   task automatic wait_done(input int base, input int limit, output int cyc);
      cyc = 0;
      while (done_cnt == base && cyc < limit) begin @(negedge clk); cyc++; end
   endtask

   typedef struct {
      logic [7:0]  din;
      bit          drive_ack;
      int          glitch_at;
      logic [10:0] exp_cap;
      bit          exp_ack;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [10:0] cap;
      int          rts_len, base, cyc;
      logic        d_before;

      // cap = {stop, parity, din[7:0], start}
      vecs[0] = '{8'hED, 1'b1, 0, 11'h7DA, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 0, 11'h600, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 0, 11'h7FE, 1'b0};
      vecs[3] = '{8'h01, 1'b1, 0, 11'h402, 1'b0};
      vecs[4] = '{8'hA5, 1'b1, 5, 11'h74A, 1'b0};
      vecs[5] = '{8'hED, 1'b0, 0, 11'h7DA, 1'b1};

      reset = 1'b1; wr_ps2 = 1'b0; din = 8'h00;
      dev_c_low = 1'b0; dev_d_low = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_tx_idle", {31'd0, tx_idle}, 32'd1);
      chk("rst_done", {31'd0, tx_done_tick}, 32'd0);
      chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
      chk("rst_tout_err", {31'd0, tout_err}, 32'd0);
      chk("rst_ps2c", {31'd0, ps2c}, 32'd1);
      chk("rst_ps2d", {31'd0, ps2d}, 32'd1);

      for (int i = 0; i < 6; i++) begin
         base = done_cnt;
         send(vecs[i].din);
         dev_run(vecs[i].drive_ack, 11, vecs[i].glitch_at, cap, rts_len, d_before);
         wait_done(base, 200, cyc);
         chk("vec_capture", {21'd0, cap}, {21'd0, vecs[i].exp_cap});
         chk("vec_rts_len", rts_len, 32'd20);
         chk("vec_start_before_release", {31'd0, d_before}, 32'd0);
         chk("vec_done_count", done_cnt - base, 32'd1);
         chk("vec_ack_err", {31'd0, ack_err}, {31'd0, vecs[i].exp_ack});
         chk("vec_tout_err", {31'd0, tout_err}, 32'd0);
         chk("vec_tx_idle", {31'd0, tx_idle}, 32'd1);
         repeat (10) @(negedge clk);
      end

      // Device stops clocking after the 4th fall.
      base = done_cnt;
      send(8'h3C);
      dev_run(1'b1, 4, 0, cap, rts_len, d_before);
      wait_done(base, 400, cyc);
      chk("tout_done", done_cnt - base, 32'd1);
      chk("tout_window", {31'd0, (cyc >= 150 && cyc <= 220)}, 32'd1);
      chk("tout_err", {31'd0, tout_err}, 32'd1);
      chk("tout_ack_err", {31'd0, ack_err}, 32'd0);
      chk("tout_tx_idle", {31'd0, tx_idle}, 32'd1);
      @(negedge clk);
      chk("tout_ps2c_released", {31'd0, ps2c}, 32'd1);
      chk("tout_ps2d_released", {31'd0, ps2d}, 32'd1);
      repeat (30) @(negedge clk);
      chk("tout_single_done", done_cnt - base, 32'd1);

      // A second request while busy must be ignored.
      base = done_cnt;
      send(8'hED);
      fork
         dev_run(1'b1, 11, 0, cap, rts_len, d_before);
         begin
            repeat (100) @(negedge clk);
            din = 8'h55; wr_ps2 = 1'b1;
            @(negedge clk);
            wr_ps2 = 1'b0;
         end
      join
      wait_done(base, 200, cyc);
      repeat (50) @(negedge clk);
      chk("busy_capture", {21'd0, cap}, 32'h7DA);
      chk("busy_single_done", done_cnt - base, 32'd1);
      chk("busy_ack_err", {31'd0, ack_err}, 32'd0);

      // Reset in the middle of the data phase.
      base = done_cnt;
      send(8'hED);
      dev_run(1'b1, 5, 0, cap, rts_len, d_before);
      chk("pre_reset_ps2d_bit4", {31'd0, ps2d}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_ps2c", {31'd0, ps2c}, 32'd1);
      chk("midrst_ps2d", {31'd0, ps2d}, 32'd1);
      chk("midrst_tx_idle", {31'd0, tx_idle}, 32'd1);
      chk("midrst_done", {31'd0, tx_done_tick}, 32'd0);
      chk("midrst_ack_err", {31'd0, ack_err}, 32'd0);
      chk("midrst_tout_err", {31'd0, tout_err}, 32'd0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("midrst_no_done", done_cnt - base, 32'd0);

      base = done_cnt;
      send(8'hF4);
      dev_run(1'b1, 11, 0, cap, rts_len, d_before);
      wait_done(base, 200, cyc);
      chk("post_rst_capture", {21'd0, cap}, 32'h5E8);
      chk("post_rst_done", done_cnt - base, 32'd1);
      chk("post_rst_ack_err", {31'd0, ack_err}, 32'd0);
      chk("post_rst_tx_idle", {31'd0, tx_idle}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
